// File: rtl/rx_frame_sync.sv
// rtl/rx_frame_sync.sv - 802.15.4 receive deframer: zero-preamble/SFD hunt, PHR length, payload stream; optional FCS check when RX_FRAME_SYNC_CRC_EN is defined
module rx_frame_sync #(
    parameter int MIN_ZERO_NIB = 6,
    parameter int TIMEOUT_CYC  = 1023
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic [3:0] inFifoData,
    input  logic       inFifoEmpty,
    output logic       outFifoReadEnable,
    output logic [7:0] outByte,
    output logic       outValid,
    input  logic       inReady,
    output logic       outSof,
    output logic       outEof,
    output logic [6:0] outLength,
    output logic       outLenError,
    output logic       outAbort,
    output logic       outCrcOk,
    output logic [7:0] outFrameCount
);

    typedef enum logic [2:0] {
        HUNT, SFD_HI, LEN_LO, LEN_HI, PAYLOAD_LO, PAYLOAD_HI
    } state_t;

`ifdef RX_FRAME_SYNC_CRC_EN
    localparam logic [6:0] MIN_LEN = 7'd3;
`else
    localparam logic [6:0] MIN_LEN = 7'd1;
`endif

    state_t      state_q, state_d;
    logic [3:0]  zcnt_q, zcnt_d;
    logic [15:0] idle_q, idle_d;
    logic        rd_pend_q, rd_pend_d;
    logic        run_q, run_d;
    logic [3:0]  nib_lo_q, nib_lo_d;
    logic [6:0]  rem_q, rem_d;
    logic        first_q, first_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic [6:0]  len_q, len_d;
    logic        len_err_q, len_err_d;
    logic        abort_q, abort_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        abort_fire;
    logic        load;
    logic        load_last;
    logic [6:0]  len_rx;

    assign len_rx = {inFifoData[2:0], nib_lo_q};
    assign run_d  = 1'b1;

`ifdef RX_FRAME_SYNC_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_ok_q, crc_ok_d;

    // Reflected CRC-16 (x^16+x^12+x^5+1), one nibble, LSB first.
    function automatic logic [15:0] crc_nib(input logic [15:0] c, input logic [3:0] n);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            if (r[0] ^ n[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // FCS accumulator: cleared when the length is taken, fed every payload nibble.
    always_comb begin
        crc_d = crc_q;
        if (rd_pend_q) begin
            if (state_q == LEN_HI) begin
                crc_d = '0;
            end else if (state_q == PAYLOAD_LO || state_q == PAYLOAD_HI) begin
                crc_d = crc_nib(crc_q, inFifoData);
            end
        end
    end
`endif

    // Parser: consumes the nibble returned by last cycle's read and runs the idle timeout.
    always_comb begin
        state_d   = state_q;
        zcnt_d    = zcnt_q;
        nib_lo_d  = nib_lo_q;
        rem_d     = rem_q;
        first_d   = first_q;
        len_d     = len_q;
        len_err_d = 1'b0;
        abort_d   = 1'b0;
        load      = 1'b0;
        load_last = 1'b0;
        if (rd_pend_q || state_q == HUNT) idle_d = '0;
        else                              idle_d = idle_q + 16'd1;
        abort_fire = !rd_pend_q && (state_q != HUNT) && (idle_q == 16'(TIMEOUT_CYC - 1));
        if (rd_pend_q) begin
            unique case (state_q)
                HUNT: begin
                    if (inFifoData == 4'h0) begin
                        if (zcnt_q != 4'hF) zcnt_d = zcnt_q + 4'd1;
                    end else if (inFifoData == 4'h7 && zcnt_q >= 4'(MIN_ZERO_NIB)) begin
                        state_d = SFD_HI;
                        zcnt_d  = '0;
                    end else begin
                        zcnt_d = '0;
                    end
                end
                SFD_HI: begin
                    if (inFifoData == 4'hA) begin
                        state_d = LEN_LO;
                    end else begin
                        state_d = HUNT;
                        // a zero here may itself start the next preamble
                        zcnt_d  = (inFifoData == 4'h0) ? 4'd1 : 4'd0;
                    end
                end
                LEN_LO: begin
                    nib_lo_d = inFifoData;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    len_d = len_rx;
                    rem_d = len_rx;
                    if (len_rx < MIN_LEN) begin
                        len_err_d = 1'b1;
                        state_d   = HUNT;
                        zcnt_d    = '0;
                    end else begin
                        first_d = 1'b1;
                        state_d = PAYLOAD_LO;
                    end
                end
                PAYLOAD_LO: begin
                    nib_lo_d = inFifoData;
                    state_d  = PAYLOAD_HI;
                end
                PAYLOAD_HI: begin
                    load      = 1'b1;
                    load_last = (rem_q == 7'd1);
                    rem_d     = rem_q - 7'd1;
                    first_d   = 1'b0;
                    if (rem_q == 7'd1) begin
                        state_d = HUNT;
                        zcnt_d  = '0;
                    end else begin
                        state_d = PAYLOAD_LO;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (abort_fire) begin
            state_d = HUNT;
            zcnt_d  = '0;
            abort_d = 1'b1;
            load    = 1'b0;
        end
    end

    // Output register: hold under backpressure, clear on handshake, reload on a completed byte.
    always_comb begin
        byte_d      = byte_q;
        valid_d     = valid_q;
        sof_d       = sof_q;
        eof_d       = eof_q;
        frame_cnt_d = frame_cnt_q;
`ifdef RX_FRAME_SYNC_CRC_EN
        crc_ok_d    = crc_ok_q;
`endif
        if (valid_q && inReady) begin
            byte_d  = '0;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
`ifdef RX_FRAME_SYNC_CRC_EN
            crc_ok_d = 1'b0;
`endif
            if (eof_q) frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (load) begin
            byte_d  = {inFifoData, nib_lo_q};
            valid_d = 1'b1;
            sof_d   = first_q;
            eof_d   = load_last;
`ifdef RX_FRAME_SYNC_CRC_EN
            crc_ok_d = load_last && (crc_d == 16'h0000);
`endif
        end
        if (abort_fire) begin
            byte_d  = '0;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
`ifdef RX_FRAME_SYNC_CRC_EN
            crc_ok_d = 1'b0;
`endif
        end
    end

    // Read strobe targets the state after the in-flight nibble; a high-nibble read waits for a free output register.
    assign outFifoReadEnable = run_q && !inReset && !inFifoEmpty &&
                               ((state_d != PAYLOAD_HI) || !valid_q || inReady);
    assign rd_pend_d = outFifoReadEnable;

    // State and output registers with synchronous reset.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            state_q     <= HUNT;
            zcnt_q      <= '0;
            idle_q      <= '0;
            rd_pend_q   <= 1'b0;
            run_q       <= 1'b0;
            nib_lo_q    <= '0;
            rem_q       <= '0;
            first_q     <= 1'b0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            len_q       <= '0;
            len_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
`ifdef RX_FRAME_SYNC_CRC_EN
            crc_q       <= '0;
            crc_ok_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            zcnt_q      <= zcnt_d;
            idle_q      <= idle_d;
            rd_pend_q   <= rd_pend_d;
            run_q       <= run_d;
            nib_lo_q    <= nib_lo_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            len_q       <= len_d;
            len_err_q   <= len_err_d;
            abort_q     <= abort_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef RX_FRAME_SYNC_CRC_EN
            crc_q       <= crc_d;
            crc_ok_q    <= crc_ok_d;
`endif
        end
    end

    assign outByte       = byte_q;
    assign outValid      = valid_q;
    assign outSof        = sof_q;
    assign outEof        = eof_q;
    assign outLength     = len_q;
    assign outLenError   = len_err_q;
    assign outAbort      = abort_q;
    assign outFrameCount = frame_cnt_q;
`ifdef RX_FRAME_SYNC_CRC_EN
    assign outCrcOk      = crc_ok_q;
`else
    assign outCrcOk      = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_sync.sv
// tb/tb_rx_frame_sync.sv - table-driven directed bench for rx_frame_sync
module tb_rx_frame_sync;

    localparam int TO = 100;
    localparam int NV = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fifo_dout = 4'h0;
    logic       fifo_empty;
    logic       rd_en;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       ready;
    logic       out_sof, out_eof;
    logic [6:0] out_length;
    logic       out_len_err, out_abort, out_crc_ok;
    logic [7:0] out_frame_count;

    always #5 clk = ~clk;

    rx_frame_sync #(.MIN_ZERO_NIB(6), .TIMEOUT_CYC(TO)) dut (
        .inClock(clk), .inReset(rst), .inFifoData(fifo_dout), .inFifoEmpty(fifo_empty),
        .outFifoReadEnable(rd_en), .outByte(out_byte), .outValid(out_valid), .inReady(ready),
        .outSof(out_sof), .outEof(out_eof), .outLength(out_length), .outLenError(out_len_err),
        .outAbort(out_abort), .outCrcOk(out_crc_ok), .outFrameCount(out_frame_count)
    );

    // FIFO model: data appears the cycle after the read strobe.
    logic [3:0] mem [0:1023];
    logic [9:0] wr_ptr = '0;
    logic [9:0] rd_ptr = '0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 10'd1;
        end
    end

    // Consumer-side monitor, sampled on the falling edge.
    logic [7:0] got_b   [0:255];
    logic       got_sof [0:255];
    logic       got_eof [0:255];
    logic       got_crc [0:255];
    int n_got = 0, n_err = 0, n_abort = 0, n_rd = 0;
    always @(negedge clk) begin
        if (!rst && out_valid && ready && n_got < 256) begin
            got_b[n_got]   = out_byte;
            got_sof[n_got] = out_sof;
            got_eof[n_got] = out_eof;
            got_crc[n_got] = out_crc_ok;
            n_got++;
        end
        if (out_len_err) n_err++;
        if (out_abort)   n_abort++;
        if (rd_en)       n_rd++;
    end

    typedef struct {
        string      name;
        int         nz;
        logic [7:0] lenb;
        int         nb;
        logic [31:0] pay;
        int         exp_nb;
        logic [6:0] exp_len;
        int         exp_err;
    } vec_t;

    vec_t       vecs [NV];
    logic [7:0] pbuf [0:15];
    int checks = 0, failures = 0, exp_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_nib(input logic [3:0] n);
        mem[wr_ptr] = n;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    task automatic push_frame(input int nz, input logic [7:0] lenb, input int nb);
        for (int i = 0; i < nz; i++) push_nib(4'h0);
        push_nib(4'h7);
        push_nib(4'hA);
        push_nib(lenb[3:0]);
        push_nib(lenb[7:4]);
        for (int i = 0; i < nb; i++) begin
            push_nib(pbuf[i][3:0]);
            push_nib(pbuf[i][7:4]);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (wr_ptr != rd_ptr && k < 3000) begin
            tick();
            k++;
        end
        check("fifo_drained", 32'(rd_ptr), 32'(wr_ptr));
        repeat (8) tick();
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!out_valid && k < 300) begin
            tick();
            k++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, ab0, rd_snap, stable_err;
        logic [7:0] held;

        vecs[0] = '{"basic",     8, 8'h03, 3, 32'h00332211, 3, 7'd3, 0};
        vecs[1] = '{"short_pre", 5, 8'h03, 3, 32'h00332211, 0, 7'd3, 0};
        vecs[2] = '{"min_pre",   6, 8'h03, 3, 32'h00EFCDAB, 3, 7'd3, 0};
        vecs[3] = '{"len_zero",  8, 8'h00, 0, 32'h00000000, 0, 7'd0, 1};
`ifdef RX_FRAME_SYNC_CRC_EN
        vecs[4] = '{"len_one",   8, 8'h01, 1, 32'h0000005C, 0, 7'd1, 1};
`else
        vecs[4] = '{"len_one",   8, 8'h01, 1, 32'h0000005C, 1, 7'd1, 0};
`endif
        vecs[5] = '{"len_bit7", 15, 8'h84, 4, 32'h08040201, 4, 7'd4, 0};

        rst   = 1'b1;
        ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rd_en",  32'(rd_en), 32'd0);
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_length", 32'(out_length), 32'd0);
        check("rst_frames", 32'(out_frame_count), 32'd0);
        tick();
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            base = n_got;
            ab0  = n_abort;
            rd_snap = n_err;
            for (int i = 0; i < 4; i++) pbuf[i] = vecs[v].pay[8*i +: 8];
            push_frame(vecs[v].nz, vecs[v].lenb, vecs[v].nb);
            drain();
            if (vecs[v].exp_nb > 0) exp_frames++;
            check({vecs[v].name, "_nbytes"}, 32'(n_got - base), 32'(vecs[v].exp_nb));
            for (int i = 0; i < vecs[v].exp_nb; i++) begin
                check({vecs[v].name, "_byte"}, 32'(got_b[base+i]), 32'(vecs[v].pay[8*i +: 8]));
                check({vecs[v].name, "_sof"},  32'(got_sof[base+i]), 32'(i == 0));
                check({vecs[v].name, "_eof"},  32'(got_eof[base+i]), 32'(i == vecs[v].exp_nb - 1));
            end
            check({vecs[v].name, "_lenerr"}, 32'(n_err - rd_snap), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_abort"},  32'(n_abort - ab0), 32'd0);
            check({vecs[v].name, "_length"}, 32'(out_length), 32'(vecs[v].exp_len));
            check({vecs[v].name, "_frames"}, 32'(out_frame_count), 32'(exp_frames & 255));
        end

        // Backpressure: consumer stalls 20 cycles on the first byte.
        ready = 1'b0;
        base  = n_got;
        pbuf[0] = 8'h10; pbuf[1] = 8'h20; pbuf[2] = 8'h30; pbuf[3] = 8'h40;
        push_frame(8, 8'h04, 4);
        wait_valid("bp_valid");
        check("bp_first_byte", 32'(out_byte), 32'h10);
        check("bp_first_sof",  32'(out_sof), 32'd1);
        held = out_byte;
        repeat (3) tick();
        rd_snap = n_rd;
        stable_err = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (out_byte !== held || out_valid !== 1'b1) stable_err++;
        end
        check("bp_stable", 32'(stable_err), 32'd0);
        check("bp_no_reads", 32'(n_rd), 32'(rd_snap));
        ready = 1'b1;
        drain();
        exp_frames++;
        check("bp_nbytes", 32'(n_got - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("bp_byte", 32'(got_b[base+i]), 32'(pbuf[i]));
            check("bp_eof",  32'(got_eof[base+i]), 32'(i == 3));
        end
        check("bp_frames", 32'(out_frame_count), 32'(exp_frames & 255));

        // Timeout: a 4-byte frame starves after its first byte.
        base = n_got;
        ab0  = n_abort;
        pbuf[0] = 8'h55;
        push_frame(8, 8'h04, 1);
        drain();
        repeat (TO - 20) tick();
        check("to_not_early", 32'(n_abort - ab0), 32'd0);
        repeat (40) tick();
        check("to_abort_once", 32'(n_abort - ab0), 32'd1);
        check("to_nbytes", 32'(n_got - base), 32'd1);
        check("to_byte", 32'(got_b[base]), 32'h55);
        check("to_valid_low", 32'(out_valid), 32'd0);
        check("to_frames", 32'(out_frame_count), 32'(exp_frames & 255));
        base = n_got;
        pbuf[0] = 8'h11; pbuf[1] = 8'h22; pbuf[2] = 8'h33;
        push_frame(8, 8'h03, 3);
        drain();
        exp_frames++;
        check("to_recover_nbytes", 32'(n_got - base), 32'd3);
        check("to_recover_frames", 32'(out_frame_count), 32'(exp_frames & 255));

`ifdef RX_FRAME_SYNC_CRC_EN
        // FCS: "123456789" has CRC 0x2189, appended low byte first.
        for (int i = 0; i < 9; i++) pbuf[i] = 8'(8'h31 + i);
        pbuf[9]  = 8'h89;
        pbuf[10] = 8'h21;
        base = n_got;
        push_frame(8, 8'd11, 11);
        drain();
        exp_frames++;
        check("crc_good_nbytes", 32'(n_got - base), 32'd11);
        check("crc_good_eof",    32'(got_eof[base+10]), 32'd1);
        check("crc_good_ok",     32'(got_crc[base+10]), 32'd1);
        pbuf[0] = 8'h30;
        base = n_got;
        push_frame(8, 8'd11, 11);
        drain();
        exp_frames++;
        check("crc_bad_nbytes", 32'(n_got - base), 32'd11);
        check("crc_bad_ok",     32'(got_crc[base+10]), 32'd0);
        check("crc_frames",     32'(out_frame_count), 32'(exp_frames & 255));
`endif

        // Reset pulse with a byte held mid-payload.
        ready = 1'b0;
        pbuf[0] = 8'h0F; pbuf[1] = 8'h0E; pbuf[2] = 8'h0D; pbuf[3] = 8'h0C;
        push_frame(8, 8'h04, 4);
        wait_valid("rst_mid_valid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_rd_en",   32'(rd_en), 32'd0);
        check("rstmid_valid",   32'(out_valid), 32'd0);
        check("rstmid_byte",    32'(out_byte), 32'd0);
        check("rstmid_sof_eof", 32'({out_sof, out_eof}), 32'd0);
        check("rstmid_length",  32'(out_length), 32'd0);
        check("rstmid_pulses",  32'({out_len_err, out_abort, out_crc_ok}), 32'd0);
        check("rstmid_frames",  32'(out_frame_count), 32'd0);
        ready = 1'b1;
        base = n_got;
        drain();
        check("rstmid_no_bytes", 32'(n_got - base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_frame_sync.md
# rx_frame_sync

Receive-side deframer that drains the 4-bit read port of the receive output FIFO (fed by the CDR) and recovers IEEE 802.15.4 PPDUs. It hunts for a zero preamble and the SFD 0xA7, captures the PHR length, and delivers payload bytes to the MAC-side consumer over a valid/ready interface. It sits directly downstream of the transceiver top and drives that top's output-FIFO read enable.

## Interface
Parameters:
- MIN_ZERO_NIB, 6: minimum consecutive 0x0 nibbles before an SFD is accepted (1..15).
- TIMEOUT_CYC, 1023: idle cycles without a received nibble, outside HUNT, before abort (1..65535).

Ports:
- inClock  in  1  single clock; all logic rises on it.
- inReset  in  1  synchronous, active-high reset.
- inFifoData  in  4  outFIFO read data; valid the cycle after outFifoReadEnable.
- inFifoEmpty  in  1  outFIFO empty flag.
- outFifoReadEnable  out  1  one-cycle read strobe to outFIFO.
- outByte  out  8  payload byte.
- outValid  out  1  outByte valid.
- inReady  in  1  consumer accepts outByte when high with outValid.
- outSof  out  1  qualifies the first payload byte (valid with outValid).
- outEof  out  1  qualifies the last payload byte (valid with outValid).
- outLength  out  7  PHR length of the current/last frame.
- outLenError  out  1  one-cycle pulse: illegal length, frame dropped.
- outAbort  out  1  one-cycle pulse: timeout abort.
- outCrcOk  out  1  FCS good, valid with outEof (see Configuration).
- outFrameCount  out  8  frames completed (incremented on the outEof handshake).

## Operation
- Nibble order: low nibble first; byte = {second nibble, first nibble}.
- Read issue: outFifoReadEnable = !inFifoEmpty && state needs a nibble && (in PAYLOAD_HI: outValid==0 || inReady). Back-to-back reads are allowed.
- States:
  - HUNT: a 0x0 nibble increments zcnt (4-bit, saturating at 15). A 0x7 nibble with zcnt>=MIN_ZERO_NIB moves to SFD_HI. Any other nibble clears zcnt.
  - SFD_HI: 0xA moves to LEN_LO. 0x0 returns to HUNT with zcnt=1. Any other nibble returns to HUNT with zcnt=0.
  - LEN_LO -> LEN_HI: outLength=byte[6:0] (bit7 ignored); remaining counter = length.
  - Length 0 (or <3 with CRC enabled) pulses outLenError and returns to HUNT. Otherwise go to PAYLOAD_LO.
  - PAYLOAD_LO -> PAYLOAD_HI: on the high nibble, load outByte and set outValid. outSof is set on the first byte; outEof when remaining==1. Then decrement remaining.
  - After the last byte, return to HUNT with zcnt=0. outValid/outEof stay held until the handshake.
- Output register holds its value while outValid && !inReady. It is cleared on the handshake unless reloaded in the same cycle.
- Timeout: an idle counter (16-bit) resets on every received nibble and counts in all non-HUNT states. At TIMEOUT_CYC it pulses outAbort, goes to HUNT, and clears outValid.
- Simultaneous abort and data load: abort wins; the data is discarded.
- outFrameCount wraps from 255 to 0.

## Timing
- Read at cycle t: nibble sampled at t+1; state advances at t+1.
- Minimum latency from the high-nibble read to outValid: 2 cycles. Maximum throughput: 1 byte per 2 cycles.
- A reset asserted in any cycle takes effect at the next edge:
  - outputs go to 0: outFifoReadEnable, outValid, outSof, outEof, outLength, outLenError, outAbort, outCrcOk, outFrameCount, outByte.
  - state goes to HUNT, zcnt to 0, idle counter to 0.
  - a read in flight is discarded.
- An empty FIFO mid-frame stalls the block with no reads until the timeout.

## Configuration
- RX_FRAME_SYNC_CRC_EN defined:
  - CRC-16 per 802.15.4 FCS: polynomial x^16+x^12+x^5+1, LSB-first, init 0x0000.
  - Computed over all payload bytes, including the 2 FCS bytes.
  - outCrcOk=1 with outEof if the residue is 0x0000.
  - Minimum legal length is 3.
- RX_FRAME_SYNC_CRC_EN undefined: no CRC logic, outCrcOk tied 0, minimum legal length is 1.

## Test plan
- FIFO holds 8 nibbles of 0x0, then 7, A, 3, 0, 1,1, 2,2, 3,3 -> bytes 0x11 (outSof), 0x22, 0x33 (outEof). outLength=3, outFrameCount=1.
- Only 5 zero nibbles before 7, A -> no frame, state stays HUNT. With 6 zero nibbles -> frame accepted.
- Length nibbles 0,0 -> outLenError pulse, no outValid. A following valid frame is received normally.
- inReady held low for 20 cycles mid-payload -> outByte stable, no reads issued after the next high nibble, no byte lost.
- FIFO goes empty after byte 1 of a 4-byte frame for TIMEOUT_CYC cycles -> single outAbort pulse, return to HUNT, outFrameCount unchanged.
- CRC_EN: frame with correct FCS -> outCrcOk=1. Same frame with one payload bit flipped -> outCrcOk=0. inReset pulsed mid-payload -> all outputs 0 on the next cycle.
